// File: rtl/sc_display_bcd_if.sv
// Channel input / display output bundle for sc_display_bcd.
// The CPU side drives in_ports; the display side receives the segment codes and the frame pulse.
interface sc_display_bcd_if #(
   parameter int NUM_CH = 3,
   parameter int DIGITS = 2,
   parameter int IN_W   = 32
);
   logic [NUM_CH*IN_W-1:0]     in_ports;
   logic [NUM_CH*DIGITS*7-1:0] hex;
   logic                       frame_done;

   modport master (output in_ports, input hex, input frame_done);
   modport slave  (input in_ports, output hex, output frame_done);
endinterface

// File: rtl/sc_display_bcd.sv
// Multi-channel binary-to-7-segment display driver built on one shared double-dabble converter.
// Optional macro SC_DISPLAY_BLANK_EN enables leading-zero blanking at commit.
module sc_display_bcd #(
   parameter int NUM_CH = 3,
   parameter int DIGITS = 2,
   parameter int IN_W   = 32
) (
   input  logic             clock,
   input  logic             reset,
   sc_display_bcd_if.slave  bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(IN_W);
   localparam int BCD_W = DIGITS * 4;
   localparam int CMP_W = (IN_W + 1 > 64) ? IN_W + 1 : 64;

   function automatic logic [CMP_W-1:0] pow10(input int n);
      logic [CMP_W-1:0] p;
      p = CMP_W'(1);
      for (int i = 0; i < n; i++) p = p * CMP_W'(10);
      return p;
   endfunction

   localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0: s = 7'h40;
         4'd1: s = 7'h79;
         4'd2: s = 7'h24;
         4'd3: s = 7'h30;
         4'd4: s = 7'h19;
         4'd5: s = 7'h12;
         4'd6: s = 7'h02;
         4'd7: s = 7'h78;
         4'd8: s = 7'h00;
         4'd9: s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {ST_SAMPLE, ST_SHIFT, ST_COMMIT} state_t;

   state_t              state_reg, state_next;
   logic [CH_W-1:0]     ch_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [IN_W-1:0]     bin_reg;
   logic [BCD_W-1:0]    bcd_reg;
   logic [BCD_W-1:0]    bcd_adj;
   logic                ovf_reg;
   logic                frame_done_reg;
   logic [DIGITS*7-1:0] commit_code;
   logic [IN_W-1:0]     ch_val [NUM_CH];
   logic [IN_W-1:0]     sel_val;
   logic                last_ch;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_in
         assign ch_val[gi] = bus.in_ports[gi*IN_W +: IN_W];
      end
      for (gi = 0; gi < DIGITS; gi++) begin : g_add3
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign sel_val = ch_val[ch_reg];
   assign last_ch = (ch_reg == CH_W'(NUM_CH - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_SAMPLE: state_next = ST_SHIFT;
         ST_SHIFT:  if (cnt_reg == CNT_W'(IN_W - 1)) state_next = ST_COMMIT;
         ST_COMMIT: state_next = ST_SAMPLE;
         default:   state_next = ST_SAMPLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= ST_SAMPLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ch_reg         <= '0;
         cnt_reg        <= '0;
         bin_reg        <= '0;
         bcd_reg        <= '0;
         ovf_reg        <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         case (state_reg)
            ST_SAMPLE: begin
               bin_reg <= sel_val;
               bcd_reg <= '0;
               cnt_reg <= '0;
               ovf_reg <= (CMP_W'(sel_val) >= LIMIT);
            end
            ST_SHIFT: begin
               // Carry out of the top nibble drops here; ovf_reg already flags those values.
               {bcd_reg, bin_reg} <= {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
               cnt_reg            <= cnt_reg + CNT_W'(1);
            end
            ST_COMMIT: begin
               ch_reg         <= last_ch ? '0 : ch_reg + CH_W'(1);
               frame_done_reg <= last_ch;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
`ifdef SC_DISPLAY_BLANK_EN
      logic lead;
      lead = 1'b1;
`endif
      commit_code = '0;
      for (int j = DIGITS - 1; j >= 0; j--) begin
         if (ovf_reg) begin
            commit_code[j*7 +: 7] = 7'h3F;
         end else begin
            commit_code[j*7 +: 7] = seg7(bcd_reg[j*4 +: 4]);
`ifdef SC_DISPLAY_BLANK_EN
            if (bcd_reg[j*4 +: 4] != 4'd0) lead = 1'b0;
            else if (lead && j != 0)       commit_code[j*7 +: 7] = 7'h7F;
`endif
         end
      end
   end

   // Each channel owns its display register; only the channel in COMMIT is written.
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_hex
         logic [DIGITS*7-1:0] hex_reg;
         always_ff @(posedge clock) begin
            if (reset)
               hex_reg <= {DIGITS{7'h7F}};
            else if (state_reg == ST_COMMIT && ch_reg == CH_W'(gi))
               hex_reg <= commit_code;
         end
         assign bus.hex[gi*DIGITS*7 +: DIGITS*7] = hex_reg;
      end
   endgenerate

   assign bus.frame_done = frame_done_reg;
endmodule
